// File: rtl/echo_pipe_hub.sv
// echo_pipe_hub: multi-channel echo hub.
//
// NCHAN request pipes, each with its own FIFO. Every accepted request is
// decoded by method id at enqueue time: id 0 echoes the payload as-is, id 1
// swaps the payload halves, any other id is accepted and dropped (counted in
// err_count). Queued messages are merged onto one indication pipe by a
// round-robin arbiter feeding a single output register.
//
// Handshake (all pipes): a beat transfers on a rising CLK edge when valid and
// ready are both 1. A raised ind_valid holds ind_data/ind_chan stable until
// ind_ready. req_ready depends only on registered FIFO counts.
//
// Ports:
//   CLK        clock, rising edge
//   nRST       asynchronous reset, active-high
//   req_valid  per-channel request valid            [NCHAN]
//   req_data   per-channel {id, payload}            [NCHAN*MSG_W]
//   req_ready  per-channel accept                   [NCHAN]
//   ind_valid  indication valid
//   ind_data   echoed {id, payload}                 [MSG_W]
//   ind_chan   source channel of ind_data           [CH_W]
//   ind_ready  downstream accept
//   err_count  saturating count of dropped unknown-id requests [16]
module echo_pipe_hub #(
    parameter int NCHAN  = 4,
    parameter int ID_W   = 16,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    localparam int MSG_W = ID_W + DATA_W,
    localparam int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCHAN-1:0]       req_valid,
    input  logic [NCHAN*MSG_W-1:0] req_data,
    output logic [NCHAN-1:0]       req_ready,
    output logic                   ind_valid,
    output logic [MSG_W-1:0]       ind_data,
    output logic [CH_W-1:0]        ind_chan,
    input  logic                   ind_ready,
    output logic [15:0]            err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int HALF  = DATA_W / 2;

    logic [MSG_W-1:0]  mem_q    [NCHAN][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NCHAN];
    logic [PTR_W-1:0]  rd_ptr_q [NCHAN];
    logic [CNT_W-1:0]  cnt_q    [NCHAN];
    logic [CNT_W-1:0]  cnt_d    [NCHAN];

    logic [ID_W-1:0]   req_id   [NCHAN];
    logic [DATA_W-1:0] req_pl   [NCHAN];
    logic [MSG_W-1:0]  push_msg [NCHAN];
    logic [NCHAN-1:0]  push;
    logic [NCHAN-1:0]  pop;
    logic [NCHAN-1:0]  drop;
    logic [4:0]        drop_n;

    logic              ind_valid_q;
    logic [MSG_W-1:0]  ind_data_q;
    logic [CH_W-1:0]   ind_chan_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [15:0]       err_q;
    logic [15:0]       err_d;
    logic [16:0]       err_sum;

    logic              load;
    logic              grant_valid;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   idx;
    logic [MSG_W-1:0]  grant_msg;

    // Ingress: ready, method decode and drop accounting.
    always_comb begin
        req_ready = '0;
        push      = '0;
        drop      = '0;
        drop_n    = '0;
        for (int i = 0; i < NCHAN; i++) begin
            req_ready[i] = (cnt_q[i] != CNT_W'(DEPTH));
            req_id[i]    = req_data[i*MSG_W+DATA_W +: ID_W];
            req_pl[i]    = req_data[i*MSG_W +: DATA_W];
            push_msg[i]  = {req_id[i], req_pl[i]};
            if (req_id[i] == ID_W'(1)) begin
                push_msg[i] = {req_id[i], req_pl[i][HALF-1:0], req_pl[i][DATA_W-1:HALF]};
            end
            if (req_valid[i] && req_ready[i]) begin
                if (req_id[i] == '0 || req_id[i] == ID_W'(1)) begin
                    push[i] = 1'b1;
                end else begin
                    drop[i] = 1'b1;
                    drop_n  = drop_n + 5'(1);
                end
            end
        end
        err_sum = {1'b0, err_q} + 17'(drop_n);
        err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Arbiter: first non-empty channel after rr_ptr, with wrap.
    always_comb begin
        load        = !ind_valid_q || ind_ready;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        pop         = '0;
        for (int k = 1; k <= NCHAN; k++) begin
            idx = CH_W'((int'(rr_ptr_q) + k) % NCHAN);
            if (!grant_valid && cnt_q[idx] != '0) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
        grant_msg = mem_q[grant][rd_ptr_q[grant]];
        for (int i = 0; i < NCHAN; i++) begin
            pop[i]   = load && grant_valid && (grant == CH_W'(i));
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // FIFO storage carries no reset; validity lives in the counts.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= push_msg[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            for (int i = 0; i < NCHAN; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            ind_valid_q <= 1'b0;
            ind_data_q  <= '0;
            ind_chan_q  <= '0;
            rr_ptr_q    <= CH_W'(NCHAN - 1);
            err_q       <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                // DEPTH is a power of two, so pointers wrap naturally.
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                cnt_q[i] <= cnt_d[i];
            end
            if (load) begin
                ind_valid_q <= grant_valid;
                if (grant_valid) begin
                    ind_data_q <= grant_msg;
                    ind_chan_q <= grant;
                    rr_ptr_q   <= grant;
                end
            end
            err_q <= err_d;
        end
    end

    assign ind_valid = ind_valid_q;
    assign ind_data  = ind_data_q;
    assign ind_chan  = ind_chan_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_echo_pipe_hub.sv
module tb_echo_pipe_hub;
    localparam int NCHAN  = 4;
    localparam int ID_W   = 16;
    localparam int DATA_W = 128;
    localparam int MSG_W  = ID_W + DATA_W;

    logic                   clk;
    logic                   nrst;
    logic [NCHAN-1:0]       req_valid;
    logic [NCHAN*MSG_W-1:0] req_data;
    logic [NCHAN-1:0]       req_ready;
    logic                   ind_valid;
    logic [MSG_W-1:0]       ind_data;
    logic [1:0]             ind_chan;
    logic                   ind_ready;
    logic [15:0]            err_count;

    int n_vec;
    int n_err;
    logic [MSG_W-1:0] exp_q[$];

    echo_pipe_hub #(.NCHAN(NCHAN), .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(4)) dut (
        .CLK       (clk),
        .nRST      (nrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ind_valid (ind_valid),
        .ind_data  (ind_data),
        .ind_chan  (ind_chan),
        .ind_ready (ind_ready),
        .err_count (err_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic set_req(input int ch, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] pl);
        req_data[ch*MSG_W +: MSG_W] = {id, pl};
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst      = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        ind_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (ind_valid !== 1'b0 || ind_data !== '0 || ind_chan !== 2'd0 || err_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d e=%h, need all zero", ind_valid, ind_data, ind_chan, err_count);
        end
        nrst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'hF) begin
            n_err++;
            $display("FAIL reset_ready: got %h need f", req_ready);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (ind_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_valid: got %b need 0", ind_valid);
        end
    endtask

    task automatic test_single_say();
        logic [DATA_W-1:0] p;
        p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ind_ready = 1'b1;
        set_req(2, 16'h0000, p);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (ind_valid !== 1'b0) begin
            n_err++;
            $display("FAIL say_latency_early: got valid=%b need 0", ind_valid);
        end
        @(negedge clk);
        n_vec++;
        if (ind_valid !== 1'b1 || ind_data !== {16'h0000, p} || ind_chan !== 2'd2) begin
            n_err++;
            $display("FAIL say_beat: got v=%b d=%h c=%0d need v=1 d=%h c=2", ind_valid, ind_data, ind_chan, {16'h0000, p});
        end
        @(negedge clk);
        n_vec++;
        if (ind_valid !== 1'b0) begin
            n_err++;
            $display("FAIL say_single_beat: got valid=%b need 0", ind_valid);
        end
    endtask

    task automatic test_say2();
        logic [DATA_W-1:0] p;
        logic [MSG_W-1:0]  e;
        p = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        e = {16'h0001, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
        ind_ready = 1'b1;
        set_req(0, 16'h0001, p);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (ind_valid !== 1'b1 || ind_data !== e || ind_chan !== 2'd0) begin
            n_err++;
            $display("FAIL say2_swap: got v=%b d=%h c=%0d need v=1 d=%h c=0", ind_valid, ind_data, ind_chan, e);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [MSG_W-1:0] e;
        do_reset();
        ind_ready = 1'b0;
        for (int m = 0; m < 3; m++) begin
            for (int ch = 0; ch < NCHAN; ch++) set_req(ch, 16'h0000, 128'(ch * 16 + m));
            req_valid = 4'hF;
            n_vec++;
            if (req_ready !== 4'hF) begin
                n_err++;
                $display("FAIL rr_ready m=%0d: got %h need f", m, req_ready);
            end
            @(negedge clk);
        end
        req_valid = '0;
        for (int h = 0; h < 3; h++) begin
            n_vec++;
            if (ind_valid !== 1'b1 || ind_data !== {16'h0000, 128'h0} || ind_chan !== 2'd0) begin
                n_err++;
                $display("FAIL rr_frozen h=%0d: got v=%b d=%h c=%0d need v=1 d=0 c=0", h, ind_valid, ind_data, ind_chan);
            end
            @(negedge clk);
        end
        ind_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            e = {16'h0000, 128'((b % 4) * 16 + b / 4)};
            n_vec++;
            if (ind_valid !== 1'b1 || ind_data !== e || ind_chan !== 2'(b % 4)) begin
                n_err++;
                $display("FAIL rr_beat%0d: got v=%b d=%h c=%0d need v=1 d=%h c=%0d", b, ind_valid, ind_data, ind_chan, e, b % 4);
            end
            @(negedge clk);
        end
        n_vec++;
        if (ind_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drained: got valid=%b need 0", ind_valid);
        end
    endtask

    task automatic test_full_fifo();
        logic             accept_now;
        logic [MSG_W-1:0] e;
        int               got;
        ind_ready = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            set_req(1, 16'h0000, 128'(100 + k));
            exp_q.push_back({16'h0000, 128'(100 + k)});
            req_valid = 4'b0010;
            n_vec++;
            if (req_ready[1] !== (k < 5)) begin
                n_err++;
                $display("FAIL full_ready k=%0d: got %b need %b", k, req_ready[1], k < 5);
            end
            if (k < 5) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (req_ready[1] !== 1'b0 || ind_valid !== 1'b1 || ind_data !== {16'h0000, 128'd100}) begin
            n_err++;
            $display("FAIL full_hold: got rdy=%b v=%b d=%h need rdy=0 v=1 d=%h", req_ready[1], ind_valid, ind_data, {16'h0000, 128'd100});
        end
        ind_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            accept_now = req_valid[1] && req_ready[1];
            if (ind_valid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                n_vec++;
                if (ind_data !== e || ind_chan !== 2'd1) begin
                    n_err++;
                    $display("FAIL full_drain%0d: got d=%h c=%0d need d=%h c=1", got, ind_data, ind_chan, e);
                end
            end
            @(negedge clk);
            if (accept_now) req_valid = '0;
        end
        n_vec++;
        if (got != 6 || req_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL full_count: got %0d beats (valid still %b) need 6 beats", got, req_valid);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (ind_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_no_dup: got valid=%b need 0", ind_valid);
        end
    endtask

    task automatic test_unknown_id();
        ind_ready = 1'b1;
        set_req(3, 16'h00FF, 128'h1234);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (err_count !== 16'd1) begin
            n_err++;
            $display("FAIL unknown_err: got %h need 0001", err_count);
        end
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (ind_valid !== 1'b0) begin
                n_err++;
                $display("FAIL unknown_no_ind c=%0d: got valid=%b need 0", c, ind_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        set_req(0, 16'h0002, 128'h0);
        set_req(1, 16'hBEEF, 128'h1);
        set_req(2, 16'hFFFF, 128'h2);
        set_req(3, 16'h1234, 128'h3);
        req_valid = 4'hF;
        repeat (1000) @(negedge clk);
        n_vec++;
        if (err_count !== 16'd4001) begin
            n_err++;
            $display("FAIL sat_partial: got %0d need 4001", err_count);
        end
        repeat (15383) @(negedge clk);
        n_vec++;
        if (err_count !== 16'hFFFD) begin
            n_err++;
            $display("FAIL sat_edge: got %h need fffd", err_count);
        end
        @(negedge clk);
        n_vec++;
        if (err_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_clip: got %h need ffff", err_count);
        end
        repeat (1116) @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (err_count !== 16'hFFFF || ind_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sat_hold: got e=%h v=%b need e=ffff v=0", err_count, ind_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        ind_ready = 1'b0;
        for (int ch = 0; ch < NCHAN; ch++) set_req(ch, 16'h0000, 128'(ch + 200));
        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (ind_valid !== 1'b1 || err_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL mid_prep: got v=%b e=%h need v=1 e=ffff", ind_valid, err_count);
        end
        #2;
        nrst = 1'b1;
        #1;
        n_vec++;
        if (ind_valid !== 1'b0 || err_count !== 16'd0 || ind_data !== '0 || req_ready !== 4'hF) begin
            n_err++;
            $display("FAIL mid_async: got v=%b e=%h d=%h r=%h need v=0 e=0 d=0 r=f", ind_valid, err_count, ind_data, req_ready);
        end
        @(negedge clk);
        nrst      = 1'b0;
        ind_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (ind_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_empty c=%0d: got valid=%b need 0", c, ind_valid);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_say();
        test_say2();
        test_round_robin();
        test_full_fifo();
        test_unknown_id();
        test_saturation();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
